// File: rtl/mysystem_mux_select_ctrl.sv
// Avalon-MM output-select register with a shadow copy that commits to the
// active select bus either immediately or on the next frame_sync rising edge,
// so downstream video muxes never switch mid-frame.
module mysystem_mux_select_ctrl #(
  parameter int unsigned     WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam int unsigned DATA_W = 32;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ARMED = 1'b1;

  localparam logic [2:0] A_DATA     = 3'd0;
  localparam logic [2:0] A_SHADOW   = 3'd1;
  localparam logic [2:0] A_OUTSET   = 3'd2;
  localparam logic [2:0] A_OUTCLEAR = 3'd3;
  localparam logic [2:0] A_CONTROL  = 3'd4;
  localparam logic [2:0] A_STATUS   = 3'd5;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] r_active;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] w_shadow_nxt;
  logic             r_sync_en;
  logic             r_irq_en;
  logic             r_done;
  logic             r_fs_d;

  logic             w_wr;
  logic             w_wr_shadow;
  logic [WIDTH-1:0] w_wd;
  logic             w_fs_rise;
  logic             w_pending;
  logic             w_commit;
  logic             w_unused;

  assign w_wr        = chipselect & ~write_n;
  // Registers 0..3 all target the shadow copy.
  assign w_wr_shadow = w_wr & ~address[2];
  assign w_wd        = writedata[WIDTH-1:0];
  assign w_fs_rise   = frame_sync & ~r_fs_d;
  assign w_pending   = (r_state == S_ARMED);
  assign w_commit    = w_pending & (~r_sync_en | w_fs_rise);
  assign w_unused    = ^writedata;

  // Commit state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a fresh shadow write re-arms even on the commit cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_wr_shadow) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (w_wr_shadow)   w_state_nxt = S_ARMED;
        else if (w_commit) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shadow update for direct load, atomic set and atomic clear.
  always_comb begin
    w_shadow_nxt = r_shadow;
    if (w_wr_shadow) begin
      case (address[1:0])
        2'd2:    w_shadow_nxt = r_shadow | w_wd;
        2'd3:    w_shadow_nxt = r_shadow & ~w_wd;
        default: w_shadow_nxt = w_wd;
      endcase
    end
  end

  // Datapath and control registers; commit copies the pre-write shadow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active  <= RESET_VALUE;
      r_shadow  <= RESET_VALUE;
      r_sync_en <= 1'b0;
      r_irq_en  <= 1'b0;
      r_done    <= 1'b0;
      r_fs_d    <= 1'b1;
    end else begin
      r_fs_d   <= frame_sync;
      r_shadow <= w_shadow_nxt;
      if (w_commit) r_active <= r_shadow;
      if (w_wr && address == A_CONTROL) begin
        r_sync_en <= writedata[0];
        r_irq_en  <= writedata[1];
      end
      if (w_commit) begin
        r_done <= 1'b1;
      end else if (w_wr && address == A_STATUS && writedata[1]) begin
        r_done <= 1'b0;
      end
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:    readdata = DATA_W'(r_active);
      A_SHADOW:  readdata = DATA_W'(r_shadow);
      A_CONTROL: readdata = {30'd0, r_irq_en, r_sync_en};
      A_STATUS:  readdata = {30'd0, r_done, w_pending};
      default:   readdata = '0;
    endcase
  end

  assign out_port = r_active;
  assign irq      = r_done & r_irq_en;

endmodule

// File: tb/tb_mysystem_mux_select_ctrl.sv
// Scoreboard bench: stimulus pushes expected values, a negedge monitor
// pops and compares them against the live DUT outputs.
module tb_mysystem_mux_select_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam logic [WIDTH-1:0] RV = 4'h5;

  localparam int K_OUT = 0;
  localparam int K_IRQ = 1;
  localparam int K_RD  = 2;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             frame_sync;
  logic [WIDTH-1:0] out_port;
  logic             irq;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  mysystem_mux_select_ctrl #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .frame_sync(frame_sync), .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against the sampled outputs.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb_q.pop_front();
      case (e.kind)
        K_OUT:   act = 32'(out_port);
        K_IRQ:   act = 32'(irq);
        default: act = readdata;
      endcase
      n_checks++;
      if (act !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic exp_out(input string n, input logic [WIDTH-1:0] v);
    sb_q.push_back('{n, K_OUT, 32'(v)});
  endtask

  task automatic exp_irq(input string n, input logic v);
    sb_q.push_back('{n, K_IRQ, 32'(v)});
  endtask

  // One register read per cycle: the monitor samples before the next edge.
  task automatic exp_rd(input string n, input logic [2:0] a, input logic [31:0] v);
    address = a;
    sb_q.push_back('{n, K_RD, v});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    frame_sync = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = '0;

    // Reset with frame_sync high.
    #1;
    exp_out("rst_out", RV);
    exp_irq("rst_irq", 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    exp_out("post_rst_out", RV);
    exp_rd("post_rst_status", 3'd5, 32'h0);
    exp_rd("post_rst_data", 3'd0, 32'h5);
    exp_rd("post_rst_shadow", 3'd1, 32'h5);

    // Sync mode with frame_sync held high from reset: no spurious edge.
    wr(3'd4, 32'h1);
    wr(3'd0, 32'hC);
    tick();
    tick();
    exp_out("fs_high_no_commit", RV);
    exp_rd("fs_high_pending", 3'd5, 32'h1);
    wr(3'd4, 32'h0);
    exp_out("syncen_clear_same_edge", RV);
    tick();
    exp_out("syncen_clear_commit", 4'hC);
    exp_rd("syncen_clear_status", 3'd5, 32'h2);
    wr(3'd5, 32'h2);
    exp_rd("done_cleared", 3'd5, 32'h0);
    frame_sync = 1'b0;

    // Immediate mode: ACTIVE follows SHADOW one cycle later.
    wr(3'd0, 32'hA);
    exp_out("imm_out_at_n", 4'hC);
    address = 3'd1;
    sb_q.push_back('{"imm_shadow_at_n", K_RD, 32'hA});
    tick();
    exp_out("imm_out_at_n1", 4'hA);
    exp_rd("imm_status", 3'd5, 32'h2);
    exp_irq("imm_irq_disabled", 1'b0);
    wr(3'd5, 32'h2);

    // Sync mode with set/clear, then a one-cycle frame pulse.
    wr(3'd4, 32'h3);
    wr(3'd1, 32'h0);
    wr(3'd2, 32'h3);
    wr(3'd3, 32'h1);
    exp_rd("setclr_shadow", 3'd1, 32'h2);
    exp_out("setclr_out_hold", 4'hA);
    exp_irq("setclr_irq_low", 1'b0);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    exp_out("pulse_commit", 4'h2);
    exp_irq("pulse_irq", 1'b1);
    wr(3'd5, 32'h2);
    exp_irq("irq_cleared", 1'b0);

    // frame_sync held high commits once per rising edge.
    wr(3'd0, 32'h8);
    frame_sync = 1'b1;
    tick();
    exp_out("held_first_commit", 4'h8);
    wr(3'd0, 32'h4);
    tick();
    tick();
    exp_out("held_no_second", 4'h8);
    frame_sync = 1'b0;
    tick();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    exp_out("held_next_rise", 4'h4);
    wr(3'd5, 32'h2);

    // Write coincident with a commit edge.
    wr(3'd0, 32'h9);
    frame_sync = 1'b1;
    wr(3'd0, 32'h7);
    frame_sync = 1'b0;
    exp_out("coinc_out_old", 4'h9);
    exp_rd("coinc_status", 3'd5, 32'h3);
    exp_rd("coinc_shadow", 3'd1, 32'h7);
    // DONE clear on the commit edge: set wins.
    frame_sync = 1'b1;
    wr(3'd5, 32'h2);
    frame_sync = 1'b0;
    exp_out("coinc_next_rise", 4'h7);
    exp_irq("set_wins_irq", 1'b1);
    exp_rd("set_wins_status", 3'd5, 32'h2);
    wr(3'd5, 32'h2);

    // Wide write truncation and unmapped reads.
    wr(3'd4, 32'h0);
    wr(3'd0, 32'hFFFF_FFFF);
    tick();
    exp_rd("wide_data", 3'd0, 32'h0000_000F);
    exp_rd("wide_shadow", 3'd1, 32'h0000_000F);
    exp_rd("rd_outset", 3'd2, 32'h0);
    exp_rd("rd_outclear", 3'd3, 32'h0);
    exp_rd("rd_addr6", 3'd6, 32'h0);
    exp_rd("rd_addr7", 3'd7, 32'h0);
    exp_rd("rd_control", 3'd4, 32'h0);

    // Reset while armed discards the pending value.
    wr(3'd4, 32'h1);
    wr(3'd0, 32'h3);
    exp_rd("armed_status", 3'd5, 32'h3);
    reset_n = 1'b0;
    exp_out("midarm_rst_out", RV);
    exp_irq("midarm_rst_irq", 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    exp_rd("midarm_status", 3'd5, 32'h0);
    exp_rd("midarm_shadow", 3'd1, 32'h5);
    for (int i = 0; i < 2; i++) begin
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      tick();
    end
    exp_out("midarm_no_commit", RV);
    exp_rd("midarm_data", 3'd0, 32'h5);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) tick();
    if (sb_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
